// File: rtl/decode_stage.sv
// RV32I decode stage: register-file read with writeback bypass, control and immediate decode,
// load-use hazard detection, and the ID/EX pipeline register with stall/flush control.
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        inValid,
    input  logic [31:0] inInstr,
    input  logic [31:0] inPc,
    output logic        inReady,
    output logic [4:0]  rs1Addr,
    output logic [4:0]  rs2Addr,
    input  logic [31:0] rs1Data,
    input  logic [31:0] rs2Data,
    input  logic        wbWrite,
    input  logic [4:0]  wbAddr,
    input  logic [31:0] wbData,
    output logic        outValid,
    output logic [31:0] outPc,
    output logic [31:0] outRs1Val,
    output logic [31:0] outRs2Val,
    output logic [31:0] outImm,
    output logic [4:0]  outRd,
    output logic [4:0]  outRs1,
    output logic [4:0]  outRs2,
    output logic [6:0]  outOpcode,
    output logic [2:0]  outFunct3,
    output logic        outFunct7b5,
    output logic        outRegWrite,
    output logic        outMemRead,
    output logic        outMemWrite,
    output logic        outIllegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        f7b5;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic        illegal;
    } idex_t;

    idex_t       idex, nxt;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [31:0] imm, rs1v, rs2v;
    logic        legal, wrOp, memRd, memWr, useR1, useR2, hazard;

    assign opc     = inInstr[6:0];
    assign rd      = inInstr[11:7];
    assign rs1Addr = inInstr[19:15];
    assign rs2Addr = inInstr[24:20];

    // Register file writes on the edge, so a same-cycle writeback must be bypassed here.
    assign rs1v = (rs1Addr == 5'd0) ? 32'd0 :
                  (wbWrite && wbAddr == rs1Addr) ? wbData : rs1Data;
    assign rs2v = (rs2Addr == 5'd0) ? 32'd0 :
                  (wbWrite && wbAddr == rs2Addr) ? wbData : rs2Data;

    always_comb begin
        imm   = '0;
        legal = 1'b1;
        wrOp  = 1'b0;
        memRd = 1'b0;
        memWr = 1'b0;
        useR1 = 1'b0;
        useR2 = 1'b0;
        case (opc)
            OP_LUI, OP_AUIPC: begin
                imm  = {inInstr[31:12], 12'b0};
                wrOp = 1'b1;
            end
            OP_JAL: begin
                imm  = {{12{inInstr[31]}}, inInstr[19:12], inInstr[20], inInstr[30:21], 1'b0};
                wrOp = 1'b1;
            end
            OP_JALR, OP_OPIMM: begin
                imm   = {{21{inInstr[31]}}, inInstr[30:20]};
                wrOp  = 1'b1;
                useR1 = 1'b1;
            end
            OP_LOAD: begin
                imm   = {{21{inInstr[31]}}, inInstr[30:20]};
                wrOp  = 1'b1;
                memRd = 1'b1;
                useR1 = 1'b1;
            end
            OP_SYSTEM: begin
                imm   = {{21{inInstr[31]}}, inInstr[30:20]};
                useR1 = 1'b1;
            end
            OP_BRANCH: begin
                imm   = {{20{inInstr[31]}}, inInstr[7], inInstr[30:25], inInstr[11:8], 1'b0};
                useR1 = 1'b1;
                useR2 = 1'b1;
            end
            OP_STORE: begin
                imm   = {{21{inInstr[31]}}, inInstr[30:25], inInstr[11:7]};
                memWr = 1'b1;
                useR1 = 1'b1;
                useR2 = 1'b1;
            end
            OP_OP: begin
                wrOp  = 1'b1;
                useR1 = 1'b1;
                useR2 = 1'b1;
            end
            OP_FENCE: ;
            default: legal = 1'b0;
        endcase
    end

    // Evaluated against the current ID/EX contents, which are the held values during a stall.
    assign hazard = inValid && idex.valid && idex.memRead && idex.rd != 5'd0 &&
                    ((idex.rd == rs1Addr && useR1) || (idex.rd == rs2Addr && useR2));
    assign inReady = flush || (!stall && !hazard);

    always_comb begin
        nxt          = '0;
        nxt.valid    = inValid;
        nxt.pc       = inPc;
        nxt.rs1v     = rs1v;
        nxt.rs2v     = rs2v;
        nxt.imm      = imm;
        nxt.rd       = rd;
        nxt.rs1      = rs1Addr;
        nxt.rs2      = rs2Addr;
        nxt.opcode   = opc;
        nxt.funct3   = inInstr[14:12];
        nxt.f7b5     = inInstr[30];
        nxt.regWrite = inValid && wrOp && rd != 5'd0;
        nxt.memRead  = inValid && memRd;
        nxt.memWrite = inValid && memWr;
        nxt.illegal  = inValid && !legal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex    <= '0;
            idex.pc <= RESET_PC;
        end else if (flush) begin
            idex <= '0;
        end else if (stall) begin
            idex <= idex;
        end else if (hazard) begin
            idex <= '0;
        end else begin
            idex <= nxt;
        end
    end

    assign outValid    = idex.valid;
    assign outPc       = idex.pc;
    assign outRs1Val   = idex.rs1v;
    assign outRs2Val   = idex.rs2v;
    assign outImm      = idex.imm;
    assign outRd       = idex.rd;
    assign outRs1      = idex.rs1;
    assign outRs2      = idex.rs2;
    assign outOpcode   = idex.opcode;
    assign outFunct3   = idex.funct3;
    assign outFunct7b5 = idex.f7b5;
    assign outRegWrite = idex.regWrite;
    assign outMemRead  = idex.memRead;
    assign outMemWrite = idex.memWrite;
    assign outIllegal  = idex.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction decode stage of the 5-stage RV32I pipeline, sitting between the IF/ID register and the execute stage.
- Drives the register file read addresses and receives the read data back.
- Bypasses same-cycle writeback, decodes control and immediate, and detects load-use hazards.
- Registers everything into the ID/EX pipeline register, with stall and flush control.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into outPc on reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  downstream hold; ID/EX register keeps its value
- flush  in  1  branch/jump redirect; kill the instruction entering ID/EX
- inValid  in  1  IF/ID holds a valid instruction
- inInstr  in  32  instruction word
- inPc  in  32  instruction PC
- inReady  out  1  upstream may advance IF/ID this cycle
- rs1Addr  out  5  register file read address 1 = inInstr[19:15]
- rs2Addr  out  5  register file read address 2 = inInstr[24:20]
- rs1Data  in  32  register file read data 1
- rs2Data  in  32  register file read data 2
- wbWrite  in  1  writeback enable (same signal as the register file write enable)
- wbAddr  in  5  writeback destination register
- wbData  in  32  writeback data
- outValid  out  1  ID/EX holds a valid instruction
- outPc  out  32  PC of the instruction in ID/EX
- outRs1Val  out  32  source operand 1 value
- outRs2Val  out  32  source operand 2 value
- outImm  out  32  sign-extended immediate
- outRd  out  5  destination register
- outRs1  out  5  source register 1 index, for forwarding
- outRs2  out  5  source register 2 index, for forwarding
- outOpcode  out  7  instruction opcode
- outFunct3  out  3  funct3 field
- outFunct7b5  out  1  instruction bit 30
- outRegWrite  out  1  instruction writes a register
- outMemRead  out  1  instruction is a load
- outMemWrite  out  1  instruction is a store
- outIllegal  out  1  opcode not in the RV32I set

Behaviour:
- rs1Addr/rs2Addr are combinational from inInstr, unconditionally.
- WB bypass: the register file writes on the clock edge, so a same-cycle read returns stale data.
  - If wbWrite && wbAddr!=0 && wbAddr==rs1Addr, the operand is wbData; otherwise rs1Data. rs2 is handled identically.
  - Index 0 always yields 0.
- Immediate by opcode:
  - LUI 0110111 / AUIPC 0010111: U-type {instr[31:12],12'b0}.
  - JAL 1101111: J-type, sign-extended, bit 0 = 0.
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011, SYSTEM 1110011: I-type, sign-extended.
  - BRANCH 1100011: B-type, bit 0 = 0.
  - STORE 0100011: S-type.
  - OP 0110011, FENCE 0001111, and any other opcode: 0.
- outIllegal = 1 for any opcode not listed above (FENCE is legal); its control bits are 0.
- Control decode:
  - regWrite = (LUI|AUIPC|JAL|JALR|LOAD|OP-IMM|OP) && rd!=0.
  - memRead = LOAD; memWrite = STORE.
- Source usage:
  - usesRs1 = every legal opcode except LUI, AUIPC, JAL, FENCE.
  - usesRs2 = BRANCH|STORE|OP.
- Load-use hazard (combinational) = inValid && outValid && outMemRead && outRd!=0 && ((outRd==rs1Addr && usesRs1) || (outRd==rs2Addr && usesRs2)).
- inReady = flush || (!stall && !hazard).
- ID/EX register update, priority order per clock edge:
  1. rst: every output register cleared to 0, except outPc = RESET_PC.
  2. flush: load a bubble. outValid=0, outRegWrite=outMemRead=outMemWrite=outIllegal=0; data fields don't-care (implementation zeroes them).
  3. stall: all ID/EX registers hold. The hazard check is evaluated against the held values.
  4. hazard: load a bubble, same as flush. IF/ID holds because inReady=0, so the instruction re-decodes next cycle with the load now past EX.
  5. else: capture the decode. outValid=inValid; if inValid=0, all control bits are forced to 0.
- One-cycle latency from IF/ID to ID/EX. Throughput is one instruction per cycle when there is no hazard or stall.
- Flush and hazard asserted together: flush wins and inReady=1.
- Reset mid-stall: reset wins; outValid=0 on the next cycle.

Test Plan:
- Reset → all out* = 0, outPc = RESET_PC. Drive ADDI x5,x0,-1 (0xFFF00293) with inValid=1 → next cycle outValid=1, outImm=0xFFFFFFFF, outRd=5, outRegWrite=1, outRs1Val=0.
- Bypass: rs1Data=0x11, wbWrite=1, wbAddr=3, wbData=0xABCD, instruction ADD x1,x3,x4 → outRs1Val=0xABCD. Repeat with wbAddr=0 → outRs1Val=0x11.
- Load-use: LW x7,0(x2) then ADD x8,x7,x1 → cycle after the LW: inReady=0 and a bubble (outValid=0); next cycle ADD captured, outRs1=7, inReady=1.
- No false hazard: LW x7 followed by LUI x7,0x12345 → no stall, outImm=0x12345000. LW x0 followed by ADD x1,x0,x0 → no stall.
- Immediates: BEQ with offset -4 (0xFE000EE3) → outImm=0xFFFFFFFC. SW with offset 8 → outImm=8, outMemWrite=1, outRegWrite=0. JAL +2048 → outImm=0x800.
- Control precedence: stall held 3 cycles → ID/EX unchanged and inReady=0. flush with stall and hazard all high → outValid=0, inReady=1. Opcode 0x7F → outIllegal=1, all control bits 0.
